// File: rtl/pp_pkg.sv
// Shared constants and types for the 8x8 partial-product multiplier front end.
// Optional signed support elsewhere is selected by PP_GEN_SIGNED_EN.
package pp_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned ROW_W  = 16;
    localparam int unsigned N_ROWS = 8;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned IDX_W  = $clog2(N_ROWS);

    typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/pp_row_gen.sv
// One partial-product row: multiplicand gated by a multiplier bit, shifted by the row index.
// PP_GEN_SIGNED_EN adds sign extension and negation of the top row for signed operands.
module pp_row_gen
    import pp_pkg::*;
(
    input  logic [OP_W-1:0]  i_a,
    input  logic             i_b_bit,
    input  logic [IDX_W-1:0] i_idx,
`ifdef PP_GEN_SIGNED_EN
    input  logic             i_signed,
`endif
    output row_t             o_row
);

    row_t w_ext;
    row_t w_shift;

    always_comb begin
        w_ext = '0;
        if (i_b_bit) begin
`ifdef PP_GEN_SIGNED_EN
            if (i_signed) begin
                w_ext = {{(ROW_W-OP_W){i_a[OP_W-1]}}, i_a};
            end else begin
                w_ext = {{(ROW_W-OP_W){1'b0}}, i_a};
            end
`else
            w_ext = {{(ROW_W-OP_W){1'b0}}, i_a};
`endif
        end
        w_shift = w_ext << i_idx;
        o_row   = w_shift;
`ifdef PP_GEN_SIGNED_EN
        // The multiplier's top bit weighs -2^(N-1), so its row enters negated.
        if (i_signed && (i_idx == IDX_W'(N_ROWS - 1))) begin
            o_row = -w_shift;
        end
`endif
    end

endmodule

// File: rtl/pp_gen_stage.sv
// Two-stage valid/ready partial-product generator feeding the 4:2 compressor tree.
// Define PP_GEN_SIGNED_EN to honour in_signed; otherwise operands are always unsigned.
module pp_gen_stage
    import pp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    input  logic                    in_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_ROWS*ROW_W-1:0] out_pp,
    output logic [TAG_W-1:0]        out_tag
);

    logic                    r_s1_valid;
    logic [OP_W-1:0]         r_s1_a;
    logic [OP_W-1:0]         r_s1_b;
    logic [TAG_W-1:0]        r_s1_tag;
    logic                    r_s2_valid;
    logic [N_ROWS*ROW_W-1:0] r_s2_pp;
    logic [TAG_W-1:0]        r_s2_tag;
    logic [TAG_W-1:0]        r_tag_cnt;

    logic                    w_s2_adv;
    logic                    w_in_ready;
    logic [N_ROWS*ROW_W-1:0] w_pp;

`ifdef PP_GEN_SIGNED_EN
    logic                    r_s1_signed;
`else
    logic                    w_unused_signed;
    assign w_unused_signed = in_signed;
`endif

    // S1 may take new operands whenever its content is leaving (or it is empty).
    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign out_pp    = r_s2_pp;
    assign out_tag   = r_s2_tag;

    for (genvar g = 0; g < N_ROWS; g++) begin : g_row
        pp_row_gen u_row (
            .i_a     (r_s1_a),
            .i_b_bit (r_s1_b[g]),
            .i_idx   (IDX_W'(g)),
`ifdef PP_GEN_SIGNED_EN
            .i_signed(r_s1_signed),
`endif
            .o_row   (w_pp[g*ROW_W +: ROW_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_pp     <= '0;
            r_s2_tag    <= '0;
            r_tag_cnt   <= '0;
`ifdef PP_GEN_SIGNED_EN
            r_s1_signed <= 1'b0;
`endif
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_a    <= in_a;
                    r_s1_b    <= in_b;
                    r_s1_tag  <= r_tag_cnt;
                    r_tag_cnt <= r_tag_cnt + TAG_W'(1);
`ifdef PP_GEN_SIGNED_EN
                    r_s1_signed <= in_signed;
`endif
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_pp  <= w_pp;
                    r_s2_tag <= r_s1_tag;
                end
            end
        end
    end

endmodule

// File: doc/pp_gen_stage.md
PP_GEN_STAGE -- requirements
Module: pp_gen_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  operand pair offered.
REQ-004 SHALL have port: in_ready  output  1  stage accepts operands this cycle.
REQ-005 SHALL have port: in_a  input  8  multiplicand.
REQ-006 SHALL have port: in_b  input  8  multiplier.
REQ-007 SHALL have port: in_signed  input  1  signed-operand request; sampled with operands.
REQ-008 SHALL have port: out_valid  output  1  partial-product set presented.
REQ-009 SHALL have port: out_ready  input  1  downstream 4:2 compressor tree consumes the set.
REQ-010 SHALL have port: out_pp  output  128  8 rows x 16 bits; row i at bits [16i+15:16i].
REQ-011 SHALL have port: out_tag  output  4  sequence tag of the presented set.

Function
REQ-012 SHALL be a 2-stage valid/ready pipeline: S1 registers operands, in_signed and tag; S2 registers the generated rows and tag.
REQ-013 SHALL accept input iff in_valid && in_ready; SHALL transfer output iff out_valid && out_ready.
REQ-014 SHALL drive in_ready = !s1_valid || s1 advancing into S2; S2 advances iff !s2_valid || out_ready.
REQ-015 SHALL present the set on out_valid exactly 2 cycles after acceptance when unstalled; SHALL sustain 1 set/cycle.
REQ-016 SHALL hold out_pp and out_tag stable while out_valid && !out_ready.
REQ-017 SHALL never drop, duplicate or reorder sets; at most 2 sets in flight.
REQ-018 SHALL, unsigned, form row i = ({8{b[i]}} & a) zero-extended to 16 bits, shifted left by i, truncated to 16 bits.
REQ-019 SHALL guarantee sum of the 8 rows modulo 2^16 equals the exact product.
REQ-020 SHALL increment an internal 4-bit tag counter on each accepted input; 15 wraps to 0; tag travels with its data.
REQ-021 SHALL, with simultaneous accept and output transfer on a full pipe, move all data one stage with no bubble.

Reset
REQ-022 SHALL on rst clear s1_valid, s2_valid and tag counter to 0; out_valid=0, out_tag=0, out_pp=0 in the cycle after rst is sampled.
REQ-023 SHALL discard in-flight sets on rst mid-operation; in_ready=1 in the first cycle after rst is released.
REQ-024 SHALL ignore in_valid while rst is high.

Configuration
REQ-025 SHALL support macro PP_GEN_SIGNED_EN.
REQ-026 SHALL, with PP_GEN_SIGNED_EN defined and in_signed=1: rows 0..6 = sign-extended (a*b[i]) << i; row 7 = two's complement of (sign-extended a*b[7]) << 7, modulo 2^16.
REQ-027 SHALL, without PP_GEN_SIGNED_EN, ignore in_signed and always use REQ-018; no signed logic compiled.

Structure
REQ-028 SHALL place OP_W=8, ROW_W=16, N_ROWS=8, TAG_W=4 in the shared multiplier package pp_pkg.
REQ-029 SHALL instantiate N_ROWS copies of combinational sub-module pp_row_gen (inputs a, bit, row index, signed; output 16-bit row).

Verification
REQ-030 SHALL cover: a=0xFF, b=0xFF, unsigned, out_ready=1 -> out_valid 2 cycles later, rows sum 0xFE01, out_tag=0.
REQ-031 SHALL cover: out_ready=0 for 5 cycles, 3 sets offered -> exactly 2 accepted, in_ready=0 afterwards; then release -> all 3 delivered in order, tags 0,1,2.
REQ-032 SHALL cover: 17 back-to-back sets -> out_tag sequence 0..15,0, one set per cycle.
REQ-033 SHALL cover: a=0x80, b=0xFF, in_signed=1 -> rows sum 0x0080 with PP_GEN_SIGNED_EN; 0x7F80 without.
REQ-034 SHALL cover: rst asserted with 2 sets in flight -> out_valid=0 and out_tag=0 next cycle, no stale set emitted, next accepted set tagged 0.
REQ-035 SHALL cover: a=0x00, b=0xA5 -> all 8 rows 0x0000.
